// File: rtl/cve2_pkg.sv
// Shared types and constants for the OBI memory responder.
// Holds the response-queue entry layout and an age helper.
package cve2_pkg;

    localparam int unsigned OBI_MAX_RESP_LATENCY = 8;
    localparam int unsigned OBI_MAX_OUTSTANDING  = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  age;
    } obi_resp_entry_t;

    function automatic logic [3:0] obi_age_inc(
        input logic [3:0] age,
        input logic [3:0] lim
    );
        return (age < lim) ? age + 4'd1 : age;
    endfunction

endpackage

// File: rtl/cve2_mem_array.sv
// Single-port word array with byte-enable writes and async read.
// Ports: clk_i, we_i, be_i[3:0], addr_i (word index), wdata_i, rdata_o.
module cve2_mem_array #(
    parameter int unsigned Words = 1024,
    localparam int unsigned Aw   = $clog2(Words)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [Aw-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [Words];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cve2_obi_mem_responder.sv
// Memory responder for the core req/gnt/rvalid port: fixed-latency,
// in-order responses, bounded outstanding requests, injectable stall.
// Ports: clk_i, rst_i (sync, high), req_i/gnt_o, addr_i, we_i, be_i,
// wdata_i, rvalid_o, rdata_o, err_o, stall_i.
module cve2_obi_mem_responder
    import cve2_pkg::*;
#(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        stall_i
);

    localparam int unsigned Aw = $clog2(MemWords);

    typedef logic [2:0] cnt_t;

    localparam logic [3:0] Lat = 4'(RespLatency);
    localparam cnt_t       Max = cnt_t'(MaxOutstanding);

    logic [31:0]     off;
    logic            in_range;
    logic [Aw-1:0]   idx;
    logic [31:0]     mem_rdata;
    logic            accept;
    logic            pop;
    logic            unused_off;
    obi_resp_entry_t new_entry;

    obi_resp_entry_t q_q [MaxOutstanding];
    obi_resp_entry_t q_d [MaxOutstanding];
    cnt_t            count_q;
    cnt_t            count_d;

    assign off        = addr_i - MemBase;
    assign in_range   = off[31:2] < 30'(MemWords);
    assign idx        = off[Aw+1:2];
    assign unused_off = ^off[1:0];

    // A slot freed by this cycle's response is only reusable next cycle.
    assign gnt_o  = req_i & ~stall_i & ~rst_i & (count_q < Max);
    assign accept = gnt_o;
    assign pop    = (count_q != '0) && (q_q[0].age == Lat);

    cve2_mem_array #(
        .Words(MemWords)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (accept & we_i & in_range),
        .be_i   (be_i),
        .addr_i (idx),
        .wdata_i(wdata_i),
        .rdata_o(mem_rdata)
    );

    // Read data is captured at acceptance, so later writes cannot leak in.
    always_comb begin
        new_entry.rdata = (in_range & ~we_i) ? mem_rdata : 32'h0;
        new_entry.err   = ~in_range;
        new_entry.age   = 4'd1;
    end

    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        for (int i = 0; i < int'(MaxOutstanding); i++) begin
            if (cnt_t'(i) < count_q) begin
                q_d[i].age = obi_age_inc(q_q[i].age, Lat);
            end
        end
        if (pop) begin
            for (int i = 0; i < int'(MaxOutstanding) - 1; i++) begin
                q_d[i] = q_d[i+1];
            end
            q_d[MaxOutstanding-1] = '0;
            count_d = count_d - cnt_t'(1);
        end
        if (accept) begin
            for (int i = 0; i < int'(MaxOutstanding); i++) begin
                if (cnt_t'(i) == count_d) begin
                    q_d[i] = new_entry;
                end
            end
            count_d = count_d + cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            for (int i = 0; i < int'(MaxOutstanding); i++) begin
                q_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            q_q     <= q_d;
        end
    end

    // Head entry is a register, so these only move on clock edges.
    assign rvalid_o = pop;
    assign rdata_o  = pop ? q_q[0].rdata : 32'h0;
    assign err_o    = pop ? q_q[0].err : 1'b0;

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// Scoreboard bench for cve2_obi_mem_responder: three instances with
// different latency/outstanding settings, directed and random traffic.
module tb_cve2_obi_mem_responder;

    localparam int N = 3;
    localparam int W = 16;
    localparam int          LAT  [N] = '{1, 3, 3};
    localparam int          MOS  [N] = '{2, 4, 2};
    localparam logic [31:0] BASE [N] = '{32'h1000, 32'h0, 32'h4000};

    typedef struct {
        int          g;
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst    [N];
    logic        req    [N];
    logic        gnt    [N];
    logic [31:0] addr   [N];
    logic        we     [N];
    logic [3:0]  be     [N];
    logic [31:0] wdata  [N];
    logic        rvalid [N];
    logic [31:0] rdata  [N];
    logic        err    [N];
    logic        stall  [N];

    exp_t        sbq [$];
    logic [31:0] mdl [N][W];
    int          pcnt   = 0;
    int          checks = 0;
    int          errors = 0;
    bit          pat [8] = '{1, 1, 0, 0, 1, 1, 0, 0};

    always #5 clk = ~clk;

    always @(posedge clk) pcnt <= pcnt + 1;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        cve2_obi_mem_responder #(
            .MemWords      (W),
            .MemBase       (BASE[g]),
            .RespLatency   (LAT[g]),
            .MaxOutstanding(MOS[g])
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst[g]),
            .req_i   (req[g]),
            .gnt_o   (gnt[g]),
            .addr_i  (addr[g]),
            .we_i    (we[g]),
            .be_i    (be[g]),
            .wdata_i (wdata[g]),
            .rvalid_o(rvalid[g]),
            .rdata_o (rdata[g]),
            .err_o   (err[g]),
            .stall_i (stall[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int g);
        req[g]   = 1'b0;
        we[g]    = 1'b0;
        be[g]    = 4'h0;
        addr[g]  = 32'h0;
        wdata[g] = 32'h0;
        stall[g] = 1'b0;
    endtask

    // Reference: word-addressed array, response due LAT cycles on.
    task automatic model_push(input int g, input logic w,
                              input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d);
        logic [31:0] off;
        int          ix;
        exp_t        e;
        off     = a - BASE[g];
        e.g     = g;
        e.due   = pcnt + LAT[g];
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if (off[31:2] < 30'(W)) begin
            ix = int'(off[31:2]);
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) mdl[g][ix][8*k +: 8] = d[8*k +: 8];
            end else begin
                e.rdata = mdl[g][ix];
            end
        end else begin
            e.err = 1'b1;
        end
        sbq.push_back(e);
    endtask

    task automatic access(input int g, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          input bit rnd_stall, input bit must_now);
        int n;
        bit done;
        req[g]   = 1'b1;
        we[g]    = w;
        addr[g]  = a;
        be[g]    = b;
        wdata[g] = d;
        n        = 0;
        done     = 0;
        while (!done && n < 40) begin
            stall[g] = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            if (gnt[g]) begin
                model_push(g, w, a, b, d);
                done = 1;
            end else begin
                n++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk($sformatf("gnt_timeout%0d", g), {31'b0, gnt[g]}, 1);
        if (must_now) chk($sformatf("gnt_wait%0d", g), n, 0);
        idle(g);
    endtask

    initial begin
        logic [31:0] pv;
        logic [31:0] ra;
        for (int g = 0; g < N; g++) begin
            rst[g] = 1'b1;
            idle(g);
        end

        fork
            forever begin
                @(negedge clk);
                for (int g = 0; g < N; g++) begin
                    int k;
                    k = -1;
                    for (int i = 0; i < sbq.size(); i++) begin
                        if (sbq[i].g == g) begin
                            k = i;
                            break;
                        end
                    end
                    if (rvalid[g]) begin
                        if (k < 0) begin
                            chk($sformatf("unexpected_rvalid%0d", g),
                                {31'b0, rvalid[g]}, 0);
                        end else begin
                            chk($sformatf("resp_cycle%0d", g), pcnt, sbq[k].due);
                            chk($sformatf("rdata%0d", g), rdata[g], sbq[k].rdata);
                            chk($sformatf("err%0d", g), {31'b0, err[g]},
                                {31'b0, sbq[k].err});
                            sbq.delete(k);
                        end
                    end else begin
                        chk($sformatf("idle_rdata%0d", g), rdata[g], 0);
                        chk($sformatf("idle_err%0d", g), {31'b0, err[g]}, 0);
                        if (k >= 0 && sbq[k].due < pcnt) begin
                            chk($sformatf("missing_rvalid%0d", g), pcnt, sbq[k].due);
                            sbq.delete(k);
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) rst[g] = 1'b0;
        chk("count_reset0", 32'(gen_dut[0].u_dut.count_q), 0);
        chk("count_reset1", 32'(gen_dut[1].u_dut.count_q), 0);
        chk("count_reset2", 32'(gen_dut[2].u_dut.count_q), 0);

        for (int g = 0; g < N; g++) begin
            for (int i = 0; i < W; i++) begin
                pv = $urandom();
                if (g == 1 && i < 4) pv = 32'(i + 1);
                if (g == 0 && i == 2) pv = 32'h0;
                if (g == 0 && i == 5) pv = 32'h11;
                access(g, 1'b1, BASE[g] + 32'(4 * i), 4'hF, pv, 0, 0);
            end
        end
        repeat (8) @(posedge clk);
        #1;

        access(0, 1'b1, BASE[0] + 8, 4'b0101, 32'hAABBCCDD, 0, 1);
        access(0, 1'b0, BASE[0] + 8, 4'h0, 32'h0, 0, 1);
        repeat (3) @(posedge clk);
        #1;

        access(0, 1'b0, BASE[0] + 32'(W * 4), 4'h0, 32'h0, 0, 1);
        access(0, 1'b1, BASE[0] - 4, 4'hF, 32'hDEADBEEF, 0, 1);
        access(0, 1'b0, BASE[0], 4'h0, 32'h0, 0, 1);
        access(0, 1'b0, BASE[0] + 32'(4 * (W - 1)), 4'h0, 32'h0, 0, 1);
        repeat (3) @(posedge clk);
        #1;

        access(0, 1'b0, BASE[0] + 20, 4'h0, 32'h0, 0, 1);
        access(0, 1'b1, BASE[0] + 20, 4'hF, 32'h22, 0, 1);
        access(0, 1'b0, BASE[0] + 20, 4'h0, 32'h0, 0, 1);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++)
            access(1, 1'b0, BASE[1] + 32'(4 * i), 4'h0, 32'h0, 0, 1);
        repeat (8) @(posedge clk);
        #1;

        req[2]  = 1'b1;
        we[2]   = 1'b0;
        addr[2] = BASE[2] + 12;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("gnt_pattern_c%0d", c), {31'b0, gnt[2]}, {31'b0, pat[c]});
            if (gnt[2]) model_push(2, 1'b0, addr[2], 4'h0, 32'h0);
            @(posedge clk);
            #1;
        end
        idle(2);
        repeat (8) @(posedge clk);
        #1;

        access(1, 1'b0, BASE[1] + 24, 4'h0, 32'h0, 0, 1);
        access(1, 1'b0, BASE[1] + 28, 4'h0, 32'h0, 0, 1);
        rst[1] = 1'b1;
        req[1] = 1'b1;
        for (int i = sbq.size() - 1; i >= 0; i--)
            if (sbq[i].g == 1) sbq.delete(i);
        @(negedge clk);
        chk("gnt_in_reset", {31'b0, gnt[1]}, 0);
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        idle(1);
        chk("count_after_reset", 32'(gen_dut[1].u_dut.count_q), 0);
        repeat (6) @(posedge clk);
        #1;
        access(1, 1'b0, BASE[1] + 24, 4'h0, 32'h0, 0, 1);
        access(1, 1'b0, BASE[1] + 28, 4'h0, 32'h0, 0, 1);
        repeat (6) @(posedge clk);
        #1;

        for (int g = 0; g < N; g++) begin
            for (int t = 0; t < 60; t++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                case ($urandom_range(0, 9))
                    0:       ra = $urandom();
                    1:       ra = BASE[g] + 32'(W * 4) + 32'(4 * $urandom_range(0, 3));
                    2:       ra = BASE[g] - 32'(4 * $urandom_range(1, 4));
                    default: ra = BASE[g] + 32'(4 * $urandom_range(0, W - 1))
                                  + 32'($urandom_range(0, 3));
                endcase
                access(g, 1'($urandom_range(0, 1)), ra, 4'($urandom()),
                       $urandom(), 1, 0);
            end
        end

        repeat (20) @(posedge clk);
        #1;
        chk("sb_leftover", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cve2_obi_mem_responder.md
# cve2_obi_mem_responder

Memory-side responder for the core's instruction/data request interface (req/gnt/rvalid protocol). Accepts core requests, performs byte-enabled word reads and writes on an internal array, and returns in-order responses after a fixed latency. Supports a bounded number of outstanding transactions and an injectable grant stall. It serves as the memory model behind the instruction or data port in core-level simulation and FPGA bring-up.

## Interface
- `MemWords`, 1024: array depth in 32-bit words; power of two, at least 4.
- `MemBase`, 32'h0000_0000: byte address of word 0; aligned to `MemWords*4`.
- `RespLatency`, 1: cycles from grant to rvalid; range 1 to 8.
- `MaxOutstanding`, 2: maximum granted-but-unanswered requests; range 1 to 4.

Ports:
- `clk_i` input 1: single clock. All logic is on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `req_i` input 1: request valid.
- `gnt_o` output 1: request accepted this cycle.
- `addr_i` input 32: byte address. Bits [1:0] are ignored.
- `we_i` input 1: 1 = write, 0 = read.
- `be_i` input 4: byte enables for writes.
- `wdata_i` input 32: write data.
- `rvalid_o` output 1: response valid, a one-cycle pulse per granted request.
- `rdata_o` output 32: read data, valid with `rvalid_o`.
- `err_o` output 1: bus error, valid with `rvalid_o`.
- `stall_i` input 1: when 1, forces `gnt_o` low (test backpressure).

## Operation
- Grant:
  - `gnt_o = req_i & ~stall_i & (count < MaxOutstanding)`. This is combinational.
  - A response retiring in the same cycle does not free a slot for that cycle.
- Acceptance happens on a cycle where `req_i & gnt_o`.
- Address decode:
  - `off = addr_i - MemBase`. The access is in range iff `off[31:2] < MemWords`.
  - Word index is `off[$clog2(MemWords)+1:2]`.
- In-range write:
  - Bytes with `be_i[k]=1` are updated at the acceptance edge.
  - Response is `err_o=0`, `rdata_o=0`.
- In-range read:
  - Data is sampled at the acceptance edge.
  - A later write cannot affect it. A write accepted earlier is always visible.
- Out-of-range access of either kind:
  - The array is untouched.
  - Response is `err_o=1`, `rdata_o=0`.
- Response queue:
  - FIFO of `MaxOutstanding` entries. Each entry holds {rdata, err, age}.
  - Push on acceptance with age=1.
  - Every cycle, all valid entries' age increments, saturating at `RespLatency`.
  - When the head's age equals `RespLatency`, drive the head on the outputs with `rvalid_o=1`, then pop.
- Ordering: responses come in strict acceptance order, at most one per cycle. There is no response backpressure.
- `count` is the number of occupied queue entries.
  - Push alone: +1. Pop alone: -1. Push and pop together: unchanged.

## Timing
- A request granted at edge t gets `rvalid_o` high in cycle t+`RespLatency`.
  - With `RespLatency=1`, the response is in the cycle immediately after the grant.
- Back-to-back grants produce back-to-back rvalids, because latency is fixed and at most one grant is made per cycle.
- Throughput:
  - Full rate when `MaxOutstanding > RespLatency`.
  - Otherwise grant stalls while `count == MaxOutstanding`.
- Outputs are registered.
  - `rvalid_o`, `rdata_o` and `err_o` change only on clock edges.
  - `rdata_o` and `err_o` return to 0 in cycles without `rvalid_o`.
- Reset values, applied on the first edge with `rst_i=1`:
  - `rvalid_o=0`, `rdata_o=0`, `err_o=0`, `count=0`, all entries invalid.
  - During reset `gnt_o` is 0 regardless of `req_i`.
  - Array contents are not reset.
- Reset mid-operation:
  - All outstanding responses are discarded and no rvalid is emitted for them.
  - Any write accepted before reset has already been committed.
- `stall_i` changes take effect combinationally on `gnt_o`. It does not delay responses already granted.

## Structure
- Add typedef `obi_resp_entry_t` to `cve2_pkg`: struct {logic [31:0] rdata; logic err; logic [3:0] age}.
- Add constant `OBI_MAX_RESP_LATENCY = 8` to `cve2_pkg`.
- One sub-module, `cve2_mem_array`:
  - Single-port word array with 4-bit byte-enable write.
  - Combinational read address, data sampled into the queue by the parent.
- Queue, counters, decode and grant logic live in the top module.

## Test plan
- Reset, then write `addr=MemBase+8`, `be=4'b0101`, `wdata=32'hAABBCCDD` over a prior 0, then read the same address.
  - Expect the read rdata to be 32'h00BB00DD, `err=0`, and both rvalids at grant+1.
- `RespLatency=3`, `MaxOutstanding=4`, four back-to-back reads of words 0 to 3 preloaded 1 to 4.
  - Expect rvalid in four consecutive cycles starting at first grant+3, with rdata 1,2,3,4.
- `RespLatency=3`, `MaxOutstanding=2`, `req_i` held high.
  - Expect `gnt_o` low on the 3rd cycle, high again the cycle after the first rvalid, and no lost or duplicated responses.
- Read at `MemBase+MemWords*4`, and write at `MemBase-4`.
  - Expect `err_o=1` and `rdata_o=0` on both.
  - A subsequent read of word 0 and of the last word shows them unmodified.
- Read of word 5 (=0x11) followed next cycle by a write of 0x22 to word 5.
  - Expect the read returns 0x11, and a later read returns 0x22.
- Assert `rst_i` for one cycle with two responses pending.
  - Expect no rvalid afterwards, `count=0`, `gnt_o` immediate on the next request, and array data retained.
